// File: rtl/mux_param.sv
`default_nettype none
// ============================================================================
//  Module      : mux_param
//  Description : Parameterized N-to-1 read multiplexer for the register bank.
//                Q is the combinational selection D[read_code]. Q_reg is a
//                clocked copy of Q, captured when rd_en is high. code_err
//                flags a read_code outside 0..N-1, which can only happen when
//                N is not a power of two.
//  Ports       : clk       - rising-edge clock
//                reset_L   - asynchronous, active-low reset (clears Q_reg)
//                read_code - binary index of the word to read
//                D         - N input words, D[i] is entry i
//                rd_en     - capture enable for Q_reg
//                Q         - combinational selected word (0 when out of range)
//                Q_reg     - registered selected word
//                code_err  - 1 when read_code >= N
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_param #(
  parameter int N    = 32,
  parameter int Bits = 64
) (
  input  logic                   clk,
  input  logic                   reset_L,
  input  logic [$clog2(N)-1:0]   read_code,
  input  logic [Bits-1:0]        D [N-1:0],
  input  logic                   rd_en,
  output logic [Bits-1:0]        Q,
  output logic [Bits-1:0]        Q_reg,
  output logic                   code_err
);

  localparam int unsigned C_CW = $clog2(N);

  logic [Bits-1:0] q_sel;
  logic [Bits-1:0] q_reg_d;
  logic [Bits-1:0] q_reg_q;

  // Compare-and-select: an out-of-range code matches no entry, so the result
  // falls through to zero without an out-of-bounds array access. A selected
  // entry carrying X/Z is passed through as-is.
  always_comb begin
    q_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (read_code == i[C_CW-1:0]) begin
        q_sel = D[i];
      end
    end
  end

  assign Q = q_sel;

  generate
    if ((1 << C_CW) == N) begin : g_pow2
      // Every encodable code is a valid entry.
      assign code_err = 1'b0;
    end else begin : g_not_pow2
      localparam logic [C_CW:0] C_N_W = N[C_CW:0];
      assign code_err = ({1'b0, read_code} >= C_N_W);
    end
  endgenerate

  // Capture the current selection (including 0 when out of range) or hold.
  always_comb begin
    q_reg_d = q_reg_q;
    if (rd_en) begin
      q_reg_d = q_sel;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      q_reg_q <= '0;
    end else begin
      q_reg_q <= q_reg_d;
    end
  end

  assign Q_reg = q_reg_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_param
//  Description : Self-checking testbench for mux_param. One instance uses the
//                default N=32/Bits=64, a second uses N=5/Bits=8 to exercise
//                the out-of-range path.
//  Revision    : 1.1 - direct checks
// ============================================================================
module tb_mux_param;

    logic        r_clk;
    logic        r_reset_L;
    logic [4:0]  r_read_code;
    logic [63:0] r_d [31:0];
    logic        r_rd_en;
    logic [63:0] w_q;
    logic [63:0] w_q_reg;
    logic        w_code_err;

    logic        r_reset5_L;
    logic [2:0]  r_read_code5;
    logic [7:0]  r_d5 [4:0];
    logic        r_rd_en5;
    logic [7:0]  w_q5;
    logic [7:0]  w_q_reg5;
    logic        w_code_err5;

    int          n_tests;
    int          n_fail;

    mux_param #(.N(32), .Bits(64)) u_dut (
        .clk      (r_clk),
        .reset_L  (r_reset_L),
        .read_code(r_read_code),
        .D        (r_d),
        .rd_en    (r_rd_en),
        .Q        (w_q),
        .Q_reg    (w_q_reg),
        .code_err (w_code_err)
    );

    mux_param #(.N(5), .Bits(8)) u_dut5 (
        .clk      (r_clk),
        .reset_L  (r_reset5_L),
        .read_code(r_read_code5),
        .D        (r_d5),
        .rd_en    (r_rd_en5),
        .Q        (w_q5),
        .Q_reg    (w_q_reg5),
        .code_err (w_code_err5)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    task automatic report_fail(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_fail++;
        $display("FAIL %s: actual %h expected %h", name, act, exp);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: actual timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        r_reset_L    = 1'b0;
        r_reset5_L   = 1'b0;
        r_read_code  = '0;
        r_read_code5 = '0;
        r_rd_en      = 1'b0;
        r_rd_en5     = 1'b0;
        for (int i = 0; i < 32; i++) r_d[i] = '0;
        for (int i = 0; i < 5; i++) r_d5[i] = '0;

        @(negedge r_clk); #1;
        n_tests++; if (w_q_reg !== 64'd0) report_fail("reset_qreg", w_q_reg, 64'd0);
        n_tests++; if (w_code_err !== 1'b0) report_fail("pow2_code_err", {63'd0, w_code_err}, 64'd0);
        @(negedge r_clk);
        r_reset_L  = 1'b1;
        r_reset5_L = 1'b1;

        @(negedge r_clk);
        r_d[6] = 64'd32; r_read_code = 5'd6; #1;
        n_tests++; if (w_q !== 64'd32) report_fail("sel6_32", w_q, 64'd32);
        n_tests++; if (w_code_err !== 1'b0) report_fail("sel6_err", {63'd0, w_code_err}, 64'd0);
        @(negedge r_clk);
        r_d[6] = 64'd30; #1;
        n_tests++; if (w_q !== 64'd30) report_fail("follow_d6", w_q, 64'd30);
        r_d[3] = 64'd77; #1;
        n_tests++; if (w_q !== 64'd30) report_fail("unselected_d3", w_q, 64'd30);
        @(negedge r_clk);
        r_read_code = 5'd2; r_d[2] = 64'd0; #1;
        n_tests++; if (w_q !== 64'd0) report_fail("sel2_zero", w_q, 64'd0);
        r_d[2] = 64'd6; #1;
        n_tests++; if (w_q !== 64'd6) report_fail("sel2_six", w_q, 64'd6);

        @(negedge r_clk);
        r_read_code = 5'd6; r_rd_en = 1'b1;
        @(negedge r_clk); #1;
        n_tests++; if (w_q_reg !== 64'd30) report_fail("capture30", w_q_reg, 64'd30);
        r_rd_en = 1'b0;

        @(negedge r_clk); #2;
        r_reset_L = 1'b0; #1;
        n_tests++; if (w_q_reg !== 64'd0) report_fail("async_reset", w_q_reg, 64'd0);
        n_tests++; if (w_q !== 64'd30) report_fail("q_during_reset", w_q, 64'd30);
        r_rd_en = 1'b1;
        @(negedge r_clk); #1;
        n_tests++; if (w_q_reg !== 64'd0) report_fail("reset_holds", w_q_reg, 64'd0);
        r_rd_en   = 1'b0;
        r_reset_L = 1'b1;

        @(negedge r_clk);
        r_rd_en = 1'b1; r_read_code = 5'd6;
        @(negedge r_clk); #1;
        n_tests++; if (w_q_reg !== 64'd30) report_fail("post_reset_capture", w_q_reg, 64'd30);
        r_rd_en = 1'b0; r_read_code = 5'd2;
        @(negedge r_clk); #1;
        n_tests++; if (w_q_reg !== 64'd30) report_fail("hold_rd_en0", w_q_reg, 64'd30);
        n_tests++; if (w_q !== 64'd6) report_fail("q_sel2_while_hold", w_q, 64'd6);

        @(negedge r_clk);
        r_d5[1] = 8'h3C; r_read_code5 = 3'd1; r_rd_en5 = 1'b1;
        @(negedge r_clk); #1;
        n_tests++; if (w_q_reg5 !== 8'h3C) report_fail("n5_preload", {56'd0, w_q_reg5}, 64'h3C);
        r_read_code5 = 3'd7; #1;
        n_tests++; if (w_q5 !== 8'd0) report_fail("n5_oor7_q", {56'd0, w_q5}, 64'd0);
        n_tests++; if (w_code_err5 !== 1'b1) report_fail("n5_oor7_err", {63'd0, w_code_err5}, 64'd1);
        @(negedge r_clk); #1;
        n_tests++; if (w_q_reg5 !== 8'd0) report_fail("n5_oor_capture", {56'd0, w_q_reg5}, 64'd0);
        r_rd_en5 = 1'b0;
        @(negedge r_clk);
        r_read_code5 = 3'd4; r_d5[4] = 8'hA5; #1;
        n_tests++; if (w_q5 !== 8'hA5) report_fail("n5_sel4_q", {56'd0, w_q5}, 64'hA5);
        n_tests++; if (w_code_err5 !== 1'b0) report_fail("n5_sel4_err", {63'd0, w_code_err5}, 64'd0);
        @(negedge r_clk);
        r_read_code5 = 3'd5; #1;
        n_tests++; if (w_q5 !== 8'd0) report_fail("n5_oor5_q", {56'd0, w_q5}, 64'd0);
        n_tests++; if (w_code_err5 !== 1'b1) report_fail("n5_oor5_err", {63'd0, w_code_err5}, 64'd1);

        for (int i = 0; i < 32; i++) r_d[i] = 64'(i + 100);
        for (int i = 0; i < 32; i++) begin
            @(negedge r_clk);
            r_read_code = 5'(i); #1;
            n_tests++;
            if (w_q !== 64'(i + 100)) report_fail($sformatf("sweep%0d", i), w_q, 64'(i + 100));
        end

        @(negedge r_clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_param.md
# mux_param

Parameterized N-to-1 read multiplexer for the register bank (BancoRegistros). Selects one of N words of Bits width by a binary read code and presents it combinationally on Q, so register-bank reads are visible in the same cycle. A registered copy of the selected word and an out-of-range flag serve downstream pipeline stages that need a clocked read value.

## Interface
Parameters:
- N, default 32: number of input words (entries in the register bank); N ≥ 2.
- Bits, default 64: width of each word.

Ports:
- clk  input  1  single clock; rising-edge active.
- reset_L  input  1  reset, asynchronous and active-low.
- read_code  input  $clog2(N)  binary index of the word to read.
- D  input  unpacked array [N-1:0] of [Bits-1:0]  input words; D[i] is entry i.
- rd_en  input  1  when 1, the selected word is captured into Q_reg on the next rising clk.
- Q  output  Bits  combinational selected word.
- Q_reg  output  Bits  registered selected word.
- code_err  output  1  combinational; 1 when read_code ≥ N.

## Operation
- Q = D[read_code] whenever read_code < N; purely combinational, no clock or reset dependence.
- Q follows any change on read_code or on the currently selected D entry with zero cycles of latency. Changes on unselected entries have no effect on Q.
- Out of range: when N is not a power of two and read_code ≥ N, Q = 0 and code_err = 1. When N is a power of two, code_err is constant 0.
- Unknown/undriven selected entry: Q propagates the entry value unchanged, with no masking.
- Registered path: on a rising clk with reset_L = 1 and rd_en = 1, Q_reg ← Q (including 0 when out of range). With rd_en = 0, Q_reg holds.
- Reset: reset_L = 0 forces Q_reg = 0 immediately, independent of clk, and holds it at 0 while low. Q and code_err are unaffected by reset.
- No internal state other than Q_reg.

## Timing
- Q and code_err: combinational, same delta/time step as the input change; no clock cycle of latency.
- Q_reg: 1 cycle latency. It reflects the Q value present just before the capturing rising edge.
- Reset assertion is asynchronous: Q_reg = 0 at once. Deassertion is sampled at rising clk; the first capture can occur on the first rising edge with reset_L = 1 and rd_en = 1.
- Simultaneous read_code change and clock edge: Q_reg captures the pre-edge Q, following standard nonblocking semantics.
- Reset asserted in the same step as a capture edge: reset wins, and Q_reg = 0.

## Test plan
- D[6] = 32, read_code = 6 → Q = 32 immediately, code_err = 0.
- With read_code still 6, change D[6] to 30 → Q = 30 in the same time step. Changing D[3] does not change Q.
- read_code = 2 with D[2] = 0, then D[2] = 6 → Q = 0, then Q = 6 without any clock.
- reset_L = 0 mid-run with Q_reg = 30 → Q_reg = 0 immediately, no clk edge needed. Release reset, then rd_en = 1 and read_code = 6 (D[6] = 30): Q_reg = 30 after one rising edge. Then rd_en = 0 and read_code = 2: Q_reg stays 30 while Q = 6.
- N = 5, Bits = 8, read_code = 7 → Q = 0, code_err = 1. Capture with rd_en = 1 → Q_reg = 0. Then read_code = 4, D[4] = 8'hA5 → Q = 8'hA5, code_err = 0.
- Sweep read_code 0..N-1 with D[i] = i+100 (N = 32, Bits = 64) → Q = i+100 for every i.
